// File: rtl/fetch_ctrl_pkg.sv
// Shared types and default parameters for the instruction fetch controller.
package fetch_ctrl_pkg;

    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_INSTR_W  = 16;
    localparam int DEF_RESET_PC = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_controller_if.sv
// Memory, redirect/halt and decoder handshake bundle of the fetch controller.
interface fetch_controller_if import fetch_ctrl_pkg::*; #(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W
);

    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_rd_en;
    logic [INSTR_W-1:0] mem_rdata;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               halt;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic               halted;

    modport master (
        output mem_addr, mem_rd_en, out_valid, out_instr, out_pc, halted,
        input  mem_rdata, redirect_valid, redirect_pc, halt, out_ready
    );

    modport slave (
        input  mem_addr, mem_rd_en, out_valid, out_instr, out_pc, halted,
        output mem_rdata, redirect_valid, redirect_pc, halt, out_ready
    );

endinterface

// File: rtl/fetch_skid_fifo.sv
// Two-entry in-order buffer holding returned instructions with their PCs.
module fetch_skid_fifo import fetch_ctrl_pkg::*; #(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic               flush_i,
    input  logic [INSTR_W-1:0] push_instr_i,
    input  logic [ADDR_W-1:0]  push_pc_i,
    output logic [1:0]         count_o,
    output logic               head_valid_o,
    output logic [INSTR_W-1:0] head_instr_o,
    output logic [ADDR_W-1:0]  head_pc_o
);

    logic [1:0]         count_q, count_d;
    logic [INSTR_W-1:0] instr0_q, instr0_d, instr1_q, instr1_d;
    logic [ADDR_W-1:0]  pc0_q, pc0_d, pc1_q, pc1_d;

    always_comb begin
        count_d  = count_q;
        instr0_d = instr0_q;
        instr1_d = instr1_q;
        pc0_d    = pc0_q;
        pc1_d    = pc1_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: if (count_q != 2'd2) begin
                    if (count_q == 2'd0) begin
                        instr0_d = push_instr_i;
                        pc0_d    = push_pc_i;
                    end else begin
                        instr1_d = push_instr_i;
                        pc1_d    = push_pc_i;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: if (count_q != 2'd0) begin
                    instr0_d = instr1_q;
                    pc0_d    = pc1_q;
                    count_d  = count_q - 2'd1;
                end
                2'b11: begin
                    // simultaneous push/pop keeps occupancy; entry 1 shifts to head when full
                    if (count_q == 2'd1) begin
                        instr0_d = push_instr_i;
                        pc0_d    = push_pc_i;
                    end else begin
                        instr0_d = instr1_q;
                        pc0_d    = pc1_q;
                        instr1_d = push_instr_i;
                        pc1_d    = push_pc_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q  <= 2'd0;
            instr0_q <= '0;
            instr1_q <= '0;
            pc0_q    <= '0;
            pc1_q    <= '0;
        end else begin
            count_q  <= count_d;
            instr0_q <= instr0_d;
            instr1_q <= instr1_d;
            pc0_q    <= pc0_d;
            pc1_q    <= pc1_d;
        end
    end

    assign count_o      = count_q;
    assign head_valid_o = (count_q != 2'd0);
    assign head_instr_o = instr0_q;
    assign head_pc_o    = pc0_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: issues reads, tracks the single in-flight response, buffers results.
// Optional perf counters are enabled with the FETCH_CTRL_PERF_EN macro.
//
// state     | meaning
// ST_IDLE   | first cycle out of reset, nothing issued
// ST_FETCH  | issuing sequential reads while buffer space allows
// ST_HALTED | halt honoured, no reads issued, buffer keeps draining
module fetch_controller import fetch_ctrl_pkg::*; #(
    parameter int          ADDR_W   = DEF_ADDR_W,
    parameter int          INSTR_W  = DEF_INSTR_W,
    parameter int unsigned RESET_PC = DEF_RESET_PC
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    fetch_controller_if.master bus
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0]        perf_fetch_cnt_o,
    output logic [31:0]        perf_stall_cnt_o
`endif
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        fifo_count;
    logic [2:0]        occupancy;
    logic              issue, push, pop;

    assign pop  = bus.out_valid & bus.out_ready;
    assign push = inflight_q & ~bus.redirect_valid;
    // slots committed once this cycle settles; a new read needs one free slot for its return
    assign occupancy = {1'b0, fifo_count} - {2'b00, pop} + {2'b00, inflight_q};
    assign issue = (state_q == ST_FETCH) & ~bus.halt & ~bus.redirect_valid
                   & (occupancy < 3'd2);

    assign bus.mem_rd_en = issue;
    assign bus.mem_addr  = issue ? pc_q : '0;
    assign bus.halted    = (state_q == ST_HALTED);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = issue ? pc_q : inflight_pc_q;
        case (state_q)
            ST_IDLE:   state_d = ST_FETCH;
            ST_FETCH:  if (bus.halt && !inflight_q) state_d = ST_HALTED;
            ST_HALTED: if (!bus.halt && !bus.redirect_valid) state_d = ST_FETCH;
            default:   state_d = ST_IDLE;
        endcase
        if (bus.redirect_valid) begin
            pc_d = bus.redirect_pc;
        end else if (issue) begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q       <= ST_IDLE;
            pc_q          <= ADDR_W'(RESET_PC);
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_skid_fifo #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_ni       (reset_ni),
        .push_i       (push),
        .pop_i        (pop),
        .flush_i      (bus.redirect_valid),
        .push_instr_i (bus.mem_rdata),
        .push_pc_i    (inflight_pc_q),
        .count_o      (fifo_count),
        .head_valid_o (bus.out_valid),
        .head_instr_o (bus.out_instr),
        .head_pc_o    (bus.out_pc)
    );

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (issue) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (bus.out_valid && !bus.out_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign perf_fetch_cnt_o = fetch_cnt_q;
    assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule
